// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// FIFO_WIDTH matches the data width of the FIFO this arbiter feeds.
package fifo_wr_arbiter_pkg;

  localparam int FIFO_WIDTH    = 16;
  localparam int ARB_NUM_REQ   = 4;
  localparam int ARB_MAX_BURST = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin selector: first set bit of req_i scanning last_i+1, last_i+2, ... modulo NUM_REQ.
// Purely combinational; no backpressure.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic                       found_o,
  output logic [$clog2(NUM_REQ)-1:0] next_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int               idx;
  logic [IDX_W-1:0] idx_w;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    found_o = 1'b0;
    next_o  = last_i;
    idx     = 0;
    idx_w   = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx   = (int'(last_i) + off) % NUM_REQ;
      idx_w = IDX_W'(idx);
      if (req_i[idx_w]) begin
        found_o = 1'b1;
        next_o  = idx_w;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; beats reach the FIFO 1 cycle after acceptance.
// Accept is withheld on fifo_full, or on almostfull while a registered write is still in flight.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int DATA_WIDTH = FIFO_WIDTH,
  parameter int MAX_BURST  = ARB_MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_en,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  can_accept;
  logic                  xfer;
  logic                  valid_g;
  logic                  last_beat;
  logic [DATA_WIDTH-1:0] sel_dat;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req_i  (req_valid),
    .last_i (grant_q),
    .found_o(pick_found),
    .next_o (pick_idx)
  );

  // The almostfull term covers the slot already claimed by the write now in flight.
  assign can_accept = (state_q == ARB_GRANT) && !fifo_full && !(fifo_almostfull && wr_en_q);
  assign last_beat  = (cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    sel_dat   = '0;
    valid_g   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == grant_q) begin
        req_ready[i] = can_accept;
        sel_dat      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        valid_g      = req_valid[i];
      end
    end
  end

  assign xfer = can_accept && valid_g;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_GRANT;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = ARB_IDLE;
        end else if (!valid_g) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign wr_en_d = xfer;
  assign dat_d   = xfer ? sel_dat : dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      dat_q   <= dat_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = dat_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenario tasks plus a random soak against a reference FIFO occupancy model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_almostfull = 1'b0;
  logic [DW-1:0]   fifo_data_in;
  logic            fifo_wr_en;
  logic [1:0]      grant_id;
  logic            busy;

  int checks = 0;
  int passed = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_full      (fifo_full),
    .fifo_almostfull(fifo_almostfull),
    .fifo_data_in   (fifo_data_in),
    .fifo_wr_en     (fifo_wr_en),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Returns at the negedge where reset is released; caller drives cycle 0 there.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    fifo_full = 1'b0;
    fifo_almostfull = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      #1;
      checks++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); else passed++;
      checks++; if (fifo_data_in !== 16'h0) $display("FAIL reset_data: got %h want 0000", fifo_data_in); else passed++;
      checks++; if (grant_id !== 2'd3) $display("FAIL reset_grant: got %0d want 3", grant_id); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else passed++;
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    bit            er [10];
    bit            ew [10];
    bit            eb [10];
    logic [15:0]   ed [10];
    logic [1:0]    eg [10];
    int            nxt;
    er = '{0,1,1,1,1,0,1,1,1,0};
    ew = '{0,0,1,1,1,1,0,1,1,0};
    eb = '{0,1,1,1,1,0,1,1,1,0};
    ed = '{16'd0,16'd0,16'd1,16'd2,16'd3,16'd4,16'd4,16'd5,16'd6,16'd6};
    eg = '{2'd3,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0};
    do_reset();
    nxt = 1;
    for (int c = 0; c < 10; c++) begin
      req_valid[0] = (nxt <= 6);
      req_data[0 +: DW] = 16'(nxt);
      #1;
      checks++; if (req_ready[0] !== er[c]) $display("FAIL single_ready c%0d: got %b want %b", c, req_ready[0], er[c]); else passed++;
      checks++; if (fifo_wr_en !== ew[c]) $display("FAIL single_wr_en c%0d: got %b want %b", c, fifo_wr_en, ew[c]); else passed++;
      checks++; if (fifo_data_in !== ed[c]) $display("FAIL single_data c%0d: got %h want %h", c, fifo_data_in, ed[c]); else passed++;
      checks++; if (busy !== eb[c]) $display("FAIL single_busy c%0d: got %b want %b", c, busy, eb[c]); else passed++;
      checks++; if (grant_id !== eg[c]) $display("FAIL single_grant c%0d: got %0d want %0d", c, grant_id, eg[c]); else passed++;
      if (req_valid[0] && req_ready[0]) nxt++;
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    int          seq [N];
    int          k, ph, m, p, b, beat;
    logic [3:0]  exp_rdy;
    bit          exp_wr;
    logic [15:0] exp_d;
    do_reset();
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int c = 0; c < 27; c++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'((i << 12) | seq[i]);
      #1;
      k = (c - 1) / 5;
      ph = (c - 1) % 5;
      exp_rdy = (c >= 1 && ph < 4) ? 4'(1 << (k % 4)) : 4'b0000;
      exp_wr = (c >= 2) && ((c - 2) % 5 < 4);
      checks++; if (req_ready !== exp_rdy) $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, exp_rdy); else passed++;
      checks++; if (fifo_wr_en !== exp_wr) $display("FAIL rr_wr_en c%0d: got %b want %b", c, fifo_wr_en, exp_wr); else passed++;
      if (c >= 1 && ph < 4) begin
        checks++; if (grant_id !== 2'(k % 4)) $display("FAIL rr_grant c%0d: got %0d want %0d", c, grant_id, k % 4); else passed++;
      end
      if (exp_wr) begin
        m = (c - 2) / 5; p = m % 4; b = m / 4; beat = (c - 2) % 5;
        exp_d = 16'((p << 12) | (b * 4 + beat));
        checks++; if (fifo_data_in !== exp_d) $display("FAIL rr_data c%0d: got %h want %h", c, fifo_data_in, exp_d); else passed++;
      end
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) seq[i]++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit          af [8];
    bit          fu [8];
    bit          er [8];
    bit          ew [8];
    bit          eb [8];
    logic [15:0] ed [8];
    int          nxt;
    af = '{0,0,1,0,0,0,0,0};
    fu = '{0,0,0,1,1,1,0,0};
    er = '{0,1,0,0,0,0,1,1};
    ew = '{0,0,1,0,0,0,0,1};
    eb = '{0,1,1,1,1,1,1,1};
    ed = '{16'd0,16'd0,16'd1,16'd1,16'd1,16'd1,16'd1,16'd2};
    do_reset();
    nxt = 1;
    for (int c = 0; c < 8; c++) begin
      req_valid[0] = 1'b1;
      req_data[0 +: DW] = 16'(nxt);
      fifo_almostfull = af[c];
      fifo_full = fu[c];
      #1;
      checks++; if (req_ready[0] !== er[c]) $display("FAIL bp_ready c%0d: got %b want %b", c, req_ready[0], er[c]); else passed++;
      checks++; if (fifo_wr_en !== ew[c]) $display("FAIL bp_wr_en c%0d: got %b want %b", c, fifo_wr_en, ew[c]); else passed++;
      checks++; if (fifo_data_in !== ed[c]) $display("FAIL bp_data c%0d: got %h want %h", c, fifo_data_in, ed[c]); else passed++;
      checks++; if (busy !== eb[c]) $display("FAIL bp_busy c%0d: got %b want %b", c, busy, eb[c]); else passed++;
      if (req_valid[0] && req_ready[0]) nxt++;
      @(negedge clk);
    end
    fifo_full = 1'b0;
    fifo_almostfull = 1'b0;
  endtask

  task automatic test_early_release();
    bit         v2 [6];
    logic [3:0] er [6];
    bit         eb [6];
    bit         ew [6];
    logic [1:0] eg [6];
    v2 = '{1,1,1,0,1,1};
    er = '{4'b0000,4'b0100,4'b0100,4'b0100,4'b0000,4'b1000};
    eb = '{0,1,1,1,0,1};
    ew = '{0,0,1,1,0,0};
    eg = '{2'd3,2'd2,2'd2,2'd2,2'd2,2'd3};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_valid = {1'b1, v2[c], 2'b00};
      req_data[2*DW +: DW] = 16'h2000 + 16'(c);
      req_data[3*DW +: DW] = 16'h3000;
      #1;
      checks++; if (req_ready !== er[c]) $display("FAIL early_ready c%0d: got %b want %b", c, req_ready, er[c]); else passed++;
      checks++; if (busy !== eb[c]) $display("FAIL early_busy c%0d: got %b want %b", c, busy, eb[c]); else passed++;
      checks++; if (fifo_wr_en !== ew[c]) $display("FAIL early_wr_en c%0d: got %b want %b", c, fifo_wr_en, ew[c]); else passed++;
      checks++; if (grant_id !== eg[c]) $display("FAIL early_grant c%0d: got %0d want %0d", c, grant_id, eg[c]); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_burst();
    int seq [N];
    do_reset();
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'((i << 12) | seq[i]);
      #1;
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) seq[i]++;
      if (c < 7) @(negedge clk);
    end
    checks++; if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'h1000) $display("FAIL mid_pre_write: got wr %b dat %h want wr 1 dat 1000", fifo_wr_en, fifo_data_in); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_wr_en !== 1'b0) $display("FAIL mid_wr_en: got %b want 0", fifo_wr_en); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
    checks++; if (grant_id !== 2'd3) $display("FAIL mid_grant: got %0d want 3", grant_id); else passed++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL mid_ready: got %b want 0000", req_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL mid_release_busy: got %b want 0", busy); else passed++;
    @(negedge clk);
    #1;
    checks++; if (grant_id !== 2'd0) $display("FAIL mid_regrant: got %0d want 0", grant_id); else passed++;
    checks++; if (req_ready !== 4'b0001) $display("FAIL mid_regrant_ready: got %b want 0001", req_ready); else passed++;
    @(negedge clk);
  endtask

  task automatic test_soak();
    int          seq [N];
    int          out_seq [N];
    bit          acc [N];
    bit          pend;
    logic [15:0] pend_dat;
    int          cnt, run, id, writes;
    bit          rd;
    do_reset();
    for (int i = 0; i < N; i++) begin seq[i] = 0; out_seq[i] = 0; acc[i] = 0; end
    pend = 0; pend_dat = '0; cnt = 0; run = 0; writes = 0;
    for (int c = 0; c < 10000; c++) begin
      fifo_full = (cnt == 8);
      fifo_almostfull = (cnt == 7);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) req_valid[i] = ($urandom_range(0, 3) != 0);
        req_data[i*DW +: DW] = 16'((i << 12) | (seq[i] & 12'hfff));
      end
      #1;
      checks++;
      if (fifo_wr_en !== pend || (pend && fifo_data_in !== pend_dat))
        $display("FAIL soak_write c%0d: got wr %b dat %h want wr %b dat %h", c, fifo_wr_en, fifo_data_in, pend, pend_dat);
      else passed++;
      if (fifo_full) begin
        checks++; if (fifo_wr_en !== 1'b0) $display("FAIL soak_write_while_full c%0d: got wr %b want 0", c, fifo_wr_en); else passed++;
      end
      if (fifo_wr_en === 1'b1) begin
        writes++;
        run++;
        id = int'(fifo_data_in[15:12]) % N;
        checks++;
        if (int'(fifo_data_in[11:0]) != (out_seq[id] & 12'hfff) || run > MB)
          $display("FAIL soak_order_burst c%0d: got seq %0d run %0d want seq %0d run<=%0d", c, fifo_data_in[11:0], run, out_seq[id] & 12'hfff, MB);
        else passed++;
        out_seq[id]++;
      end else begin
        run = 0;
      end
      pend = 0;
      for (int i = 0; i < N; i++) begin
        acc[i] = req_valid[i] && req_ready[i];
        if (acc[i]) begin
          pend = 1;
          pend_dat = req_data[i*DW +: DW];
          seq[i]++;
        end
      end
      rd = (cnt > 0) && ($urandom_range(0, 9) < 4);
      cnt = cnt + (fifo_wr_en ? 1 : 0) - (rd ? 1 : 0);
      if (cnt > 8) cnt = 8;
      @(negedge clk);
    end
    checks++; if (writes < 1000) $display("FAIL soak_progress: got %0d writes want >=1000", writes); else passed++;
    req_valid = '0;
    fifo_full = 1'b0;
    fifo_almostfull = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_soak();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single FIFO write port (data_in / wr_en) among NUM_REQ independent producers.
- Round-robin grant with bounded bursts: a granted producer may write up to MAX_BURST beats before the grant rotates.
- Respects FIFO full/almostfull backpressure so the FIFO never sees a write while full.
- Sits between producer blocks and the FIFO write side; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DATA_WIDTH, 16, FIFO data width
- MAX_BURST, 4, max beats accepted per grant (>=1)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-producer beat valid
- req_data  input  NUM_REQ*DATA_WIDTH  producer i data in slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-producer accept, combinational
- fifo_full  input  1  FIFO full flag
- fifo_almostfull  input  1  FIFO one-slot-left flag
- fifo_data_in  output  DATA_WIDTH  to FIFO data_in, registered
- fifo_wr_en  output  1  to FIFO wr_en, registered
- grant_id  output  $clog2(NUM_REQ)  current/last granted producer
- busy  output  1  high in GRANT state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, fifo_wr_en=0, fifo_data_in=0, grant_id=NUM_REQ-1 (so producer 0 has first priority), beat_cnt=0, busy=0, req_ready=0.
- FSM, two states:
  - IDLE: if any req_valid, grant the first valid index scanning grant_id+1, grant_id+2, ... modulo NUM_REQ; load grant_id, beat_cnt=0, go to GRANT. Otherwise stay in IDLE. No data is accepted in IDLE, so there is one bubble per grant.
  - GRANT: transfer on beat when req_valid[grant_id] && req_ready[grant_id].
    - Per transfer: beat_cnt += 1.
    - Exit to IDLE when a transfer occurs with beat_cnt == MAX_BURST-1, or when req_valid[grant_id] == 0 in a cycle with no transfer.
    - Stay in GRANT while stalled by backpressure with valid held high.
- Accept condition: req_ready[i] = (state==GRANT) && (i==grant_id) && !fifo_full && !(fifo_almostfull && fifo_wr_en). The last term blocks accepting a beat when the in-flight registered write will consume the final slot.
- Write path: on a transfer, on the next posedge fifo_data_in <= req_data slice, fifo_wr_en <= 1. With no transfer, fifo_wr_en <= 0 and fifo_data_in holds its value.
- Latency: a producer beat appears at the FIFO exactly 1 cycle after acceptance. Sustained throughput is 1 beat/cycle within a burst.
- Ordering: beats from one producer reach the FIFO in acceptance order. No interleaving of producers within a burst.
- Fairness: after a grant to i, every other valid producer is granted before i again. Worst-case wait is (NUM_REQ-1)*(MAX_BURST+1) cycles of grant time, excluding backpressure.
- Producer obligation: keep valid and data stable until ready. The arbiter does not check this.
- Reset mid-burst: all state is cleared immediately. An in-flight fifo_wr_en drops asynchronously, and the beat is lost by design.
- Invariant: fifo_wr_en && fifo_full never holds on the same posedge.

Decomposition:
- shared_pkg:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e
  - default constants ARB_NUM_REQ, ARB_MAX_BURST
  - reuse of the existing FIFO_WIDTH
- One sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: NUM_REQ-bit request vector, last index.
  - Outputs: found flag, next index.
  - Unit-testable on its own.

Test Plan:
- Single producer: req_valid=4'b0001 streaming 0x0001..0x0006, FIFO empty. Expect grant_id=0 and beats 1..4 written on consecutive cycles. Then an IDLE bubble, re-grant to 0, and 5..6 written. FIFO read order is 0x0001..0x0006.
- Round robin: all four valid continuously, each with unique data. Expect grant order 0,1,2,3,0, 4 beats per grant, a 1-cycle bubble between grants, and wr_en pattern 1111_0 repeating.
- Backpressure: fifo_almostfull=1 while a write is in flight. Expect req_ready=0 that cycle. fifo_full=1 for 3 cycles keeps wr_en=0 and the grant held; the first beat is written 1 cycle after full drops. No write ever lands while full.
- Early release: producer 2 drops valid after 2 beats. Expect a return to IDLE with beat_cnt not reaching 4, and the next grant goes to producer 3 (if valid) rather than 2.
- Reset mid-burst: rst_n=0 asynchronously during beat 2 of producer 1. Expect fifo_wr_en=0 immediately, busy=0, grant_id=NUM_REQ-1. After release with all valid, the first grant goes to producer 0.
- Random soak: 10000 cycles of random valid/data and random full/almostfull consistent with a reference FIFO model. The scoreboard checks per-producer ordering, no write while full, and the burst length bound.
